// File: rtl/joy_map_pkg.sv
// Shared definitions for the analog-stick direction mapper: joystick bit
// positions, per-axis state encoding and run-source selection codes.
package joy_map_pkg;

    localparam int JB_RIGHT = 0;
    localparam int JB_LEFT  = 1;
    localparam int JB_DOWN  = 2;
    localparam int JB_UP    = 3;

    localparam int MAP_DIG = 0;
    localparam int MAP_ANA = 1;
    localparam int MAP_OR  = 2;

    // Axis slots inside one pad's group of four hysteresis instances
    localparam int AX_LX = 0;
    localparam int AX_LY = 1;
    localparam int AX_RX = 2;
    localparam int AX_RY = 3;

    typedef enum logic [1:0] {
        AX_NEUTRAL = 2'd0,
        AX_NEG     = 2'd1,
        AX_POS     = 2'd2
    } axis_state_t;

    function automatic logic [3:0] axes_to_dir(axis_state_t x_st, axis_state_t y_st);
        logic [3:0] dir_v;
        dir_v           = 4'b0000;
        dir_v[JB_UP]    = (y_st == AX_NEG);
        dir_v[JB_DOWN]  = (y_st == AX_POS);
        dir_v[JB_LEFT]  = (x_st == AX_NEG);
        dir_v[JB_RIGHT] = (x_st == AX_POS);
        return dir_v;
    endfunction

endpackage

// File: rtl/joy_axis_hyst.sv
// Single analog axis: three-state hysteresis with a consecutive-sample filter.
// state_next is the value the state register takes at the coming edge.
module joy_axis_hyst
    import joy_map_pkg::*;
#(
    parameter int ON_TH      = 48,
    parameter int OFF_TH     = 32,
    parameter int FILTER_LEN = 2
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_sample,
    input  logic [7:0]  axis_val,
    output axis_state_t state_next
);

    localparam logic [8:0] ON_W  = 9'(ON_TH);
    localparam logic [8:0] OFF_W = 9'(OFF_TH);
    localparam logic [3:0] LEN_W = 4'(FILTER_LEN);

    axis_state_t state_r;
    axis_state_t pend_r;
    axis_state_t cand_s;
    axis_state_t state_next_s;
    axis_state_t pend_next_s;
    logic [3:0]  cnt_r;
    logic [3:0]  cnt_next_s;
    logic [3:0]  cnt_inc_s;
    logic [8:0]  mag_s;
    logic        neg_on_s;
    logic        pos_on_s;
    logic        below_off_s;

    // Nine-bit magnitude so that -128 becomes +128 instead of wrapping
    always_comb begin
        if (axis_val[7]) begin
            mag_s = 9'd0 - {1'b1, axis_val};
        end else begin
            mag_s = {1'b0, axis_val};
        end
        neg_on_s    = axis_val[7] & (mag_s >= ON_W);
        pos_on_s    = ~axis_val[7] & (mag_s >= ON_W);
        below_off_s = (mag_s < OFF_W);
    end

    // Candidate target state; equal to state_r when nothing qualifies
    always_comb begin
        cand_s = state_r;
        case (state_r)
            AX_NEUTRAL: begin
                if (neg_on_s) begin
                    cand_s = AX_NEG;
                end else if (pos_on_s) begin
                    cand_s = AX_POS;
                end else begin
                    cand_s = AX_NEUTRAL;
                end
            end
            AX_NEG: begin
                if (pos_on_s) begin
                    cand_s = AX_POS;
                end else if (below_off_s) begin
                    cand_s = AX_NEUTRAL;
                end else begin
                    cand_s = AX_NEG;
                end
            end
            AX_POS: begin
                if (neg_on_s) begin
                    cand_s = AX_NEG;
                end else if (below_off_s) begin
                    cand_s = AX_NEUTRAL;
                end else begin
                    cand_s = AX_POS;
                end
            end
            default: cand_s = AX_NEUTRAL;
        endcase
    end

    // Filter: a candidate must persist FILTER_LEN ce samples before it commits
    always_comb begin
        state_next_s = state_r;
        pend_next_s  = pend_r;
        cnt_next_s   = cnt_r;
        cnt_inc_s    = 4'd1;
        if (ce_sample) begin
            if (cand_s == state_r) begin
                cnt_next_s = 4'd0;
            end else begin
                if ((cand_s == pend_r) && (cnt_r != 4'd0)) begin
                    cnt_inc_s = cnt_r + 4'd1;
                end else begin
                    cnt_inc_s = 4'd1;
                end
                pend_next_s = cand_s;
                if (cnt_inc_s >= LEN_W) begin
                    state_next_s = cand_s;
                    cnt_next_s   = 4'd0;
                end else begin
                    cnt_next_s   = cnt_inc_s;
                end
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    // Axis state, pending candidate and streak counter
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= AX_NEUTRAL;
            pend_r  <= AX_NEUTRAL;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_next_s;
            pend_r  <= pend_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    assign state_next = state_next_s;

endmodule

// File: rtl/joy_analog_dir_map.sv
// Maps per-pad analog sticks to direction vectors, merges the left stick with
// the d-pad (SOCD-resolved) and tracks the most recently active pad.
module joy_analog_dir_map
    import joy_map_pkg::*;
#(
    parameter  int NUM_PADS   = 2,
    parameter  int ON_TH      = 48,
    parameter  int OFF_TH     = 32,
    parameter  int FILTER_LEN = 2,
    parameter  int MODE       = 2,
    localparam int AP_W       = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ce_sample,
    input  logic [NUM_PADS*32-1:0] joy_dig,
    input  logic [NUM_PADS*16-1:0] analog_l,
    input  logic [NUM_PADS*16-1:0] analog_r,
    output logic [NUM_PADS*4-1:0]  run_dir,
    output logic [NUM_PADS*4-1:0]  aim_dir,
    output logic [AP_W-1:0]        active_pad
);

    axis_state_t               ax_next_s [4*NUM_PADS];
    logic [7:0]                ax_val_s  [4*NUM_PADS];
    logic [NUM_PADS*4-1:0]     run_next_s;
    logic [NUM_PADS*4-1:0]     aim_next_s;
    logic [AP_W-1:0]           active_next_s;
    logic [NUM_PADS*4-1:0]     run_dir_r;
    logic [NUM_PADS*4-1:0]     aim_dir_r;
    logic [AP_W-1:0]           active_pad_r;

    function automatic logic [3:0] socd_resolve(logic [3:0] dir_v);
        logic [3:0] res_v;
        res_v           = 4'b0000;
        res_v[JB_UP]    = dir_v[JB_UP] & ~dir_v[JB_DOWN];
        res_v[JB_DOWN]  = dir_v[JB_DOWN] & ~dir_v[JB_UP];
        res_v[JB_LEFT]  = dir_v[JB_LEFT] & ~dir_v[JB_RIGHT];
        res_v[JB_RIGHT] = dir_v[JB_RIGHT] & ~dir_v[JB_LEFT];
        return res_v;
    endfunction

    function automatic logic [3:0] run_merge(logic [3:0] dig_v, logic [3:0] ana_v);
        logic [3:0] mrg_v;
        case (MODE)
            MAP_DIG: mrg_v = dig_v;
            MAP_ANA: mrg_v = ana_v;
            MAP_OR:  mrg_v = dig_v | ana_v;
            default: mrg_v = dig_v | ana_v;
        endcase
        return socd_resolve(mrg_v);
    endfunction

    for (genvar g = 0; g < 4*NUM_PADS; g++) begin : g_axis
        if ((g % 4) < 2) begin : g_left
            assign ax_val_s[g] = analog_l[16*(g/4) + 8*(g%2) +: 8];
        end else begin : g_right
            assign ax_val_s[g] = analog_r[16*(g/4) + 8*(g%2) +: 8];
        end

        joy_axis_hyst #(
            .ON_TH      (ON_TH),
            .OFF_TH     (OFF_TH),
            .FILTER_LEN (FILTER_LEN)
        ) u_axis (
            .clk_sys    (clk_sys),
            .reset      (reset),
            .ce_sample  (ce_sample),
            .axis_val   (ax_val_s[g]),
            .state_next (ax_next_s[g])
        );
    end

    // Outputs are built from the axis states committing at this edge, so a
    // one-sample filter shows up after a single register stage
    always_comb begin
        run_next_s    = {(NUM_PADS*4){1'b0}};
        aim_next_s    = {(NUM_PADS*4){1'b0}};
        active_next_s = active_pad_r;
        for (int p = NUM_PADS - 1; p >= 0; p--) begin
            run_next_s[4*p +: 4] = run_merge(joy_dig[32*p +: 4],
                axes_to_dir(ax_next_s[4*p + AX_LX], ax_next_s[4*p + AX_LY]));
            aim_next_s[4*p +: 4] = axes_to_dir(ax_next_s[4*p + AX_RX], ax_next_s[4*p + AX_RY]);
            if ((joy_dig[32*p +: 32] != 32'd0) ||
                (ax_next_s[4*p + AX_LX] != AX_NEUTRAL) || (ax_next_s[4*p + AX_LY] != AX_NEUTRAL) ||
                (ax_next_s[4*p + AX_RX] != AX_NEUTRAL) || (ax_next_s[4*p + AX_RY] != AX_NEUTRAL)) begin
                active_next_s = AP_W'(p);
            end else begin
                active_next_s = active_next_s;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            run_dir_r    <= {(NUM_PADS*4){1'b0}};
            aim_dir_r    <= {(NUM_PADS*4){1'b0}};
            active_pad_r <= {AP_W{1'b0}};
        end else begin
            run_dir_r    <= run_next_s;
            aim_dir_r    <= aim_next_s;
            active_pad_r <= active_next_s;
        end
    end

    assign run_dir    = run_dir_r;
    assign aim_dir    = aim_dir_r;
    assign active_pad = active_pad_r;

endmodule

// File: doc/joy_analog_dir_map.md
Name: joy_analog_dir_map

Overview:
- Converts per-pad MiSTer analog stick words (left and right sticks) into 4-bit direction vectors, with hysteresis and a consecutive-sample filter on each axis.
- Merges the left-stick result with the digital d-pad and resolves opposing directions.
- Tracks which pad was active most recently.
- Sits in emu between hps_io and the game core, feeding the run and aim inputs of twin-stick titles for NUM_PADS players.

Parameters:
- NUM_PADS, 2: number of pads/players handled. Range 1..4.
- ON_TH, 48: axis magnitude (0..128) at which a direction asserts.
- OFF_TH, 32: magnitude below which an asserted direction releases. Must satisfy OFF_TH < ON_TH.
- FILTER_LEN, 2: consecutive qualifying samples required before any axis state change. Range 1..15.
- MODE, 2: run source. 0 = digital only, 1 = analog only, 2 = digital OR analog.

Ports:
- clk_sys, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- ce_sample, in, 1: sample strobe. Axis logic advances only on cycles where this is 1.
- joy_dig, in, NUM_PADS*32: digital joystick words, pad p at [32p+31:32p]. Bits [3:0] = up, down, left, right at indices 3, 2, 1, 0.
- analog_l, in, NUM_PADS*16: left stick, pad p at [16p+15:16p]. [7:0] = X signed, [15:8] = Y signed. Negative X = left, negative Y = up.
- analog_r, in, NUM_PADS*16: right stick, same format as analog_l.
- run_dir, out, NUM_PADS*4: merged move direction per pad, bit order {up, down, left, right}.
- aim_dir, out, NUM_PADS*4: right-stick aim direction per pad, same bit order.
- active_pad, out, max(1,$clog2(NUM_PADS)): index of the most recently active pad.

Behaviour:
- Reset: every output is 0, all axis states are NEUTRAL, all filter counters are 0. Reset asserted mid-filter discards partial counts.
- Per axis (4 per pad: LX, LY, RX, RY) the state is one of NEUTRAL, NEG, POS. Magnitude is computed in 9 bits, so -128 gives 128 with no overflow.
- Candidate transition, evaluated on ce_sample cycles only:
  - NEUTRAL -> NEG when value <= -ON_TH; NEUTRAL -> POS when value >= ON_TH.
  - NEG or POS -> NEUTRAL when magnitude < OFF_TH.
  - NEG <-> POS directly when the opposite side reaches ON_TH (a fast flick).
- Filter: each ce_sample cycle on which the same candidate is still qualifying increments the counter. When the count reaches FILTER_LEN, the state changes and the counter clears. A non-qualifying sample, or a different candidate, resets the counter to 0.
- With FILTER_LEN = 1: value sampled at ce cycle N appears on the output at cycle N+1, i.e. one register stage.
- Axis to bit mapping: X NEG = left, X POS = right, Y NEG = up, Y POS = down.
- Run merge:
  - MODE 0: joy_dig bits only. MODE 1: left-stick analog only. MODE 2: bitwise OR of the two.
  - After the merge, SOCD resolution: if up and down are both set, both clear; same for left and right.
  - Digital bits are registered every clk_sys cycle, independent of ce_sample.
- Aim: right-stick axis states only. No digital source, no SOCD step needed because an axis cannot be NEG and POS at once.
- active_pad: updates to p when pad p has a nonzero joy_dig or any non-NEUTRAL axis. If several pads are active in the same cycle, the lowest index wins. Holds its value when no pad is active. Registered, one cycle latency.
- When ce_sample is 0, axis states and counters hold.
- Outputs are fully registered; there are no combinational paths from input to output.

Decomposition:
- Shared package joy_map_pkg holds:
  - bit index constants JB_RIGHT = 0, JB_LEFT = 1, JB_DOWN = 2, JB_UP = 3;
  - axis_state_t enum {AX_NEUTRAL, AX_NEG, AX_POS};
  - MODE constants MAP_DIG, MAP_ANA, MAP_OR.
- One sub-module, joy_axis_hyst: a single-axis hysteresis and filter FSM, parameterised by ON_TH, OFF_TH and FILTER_LEN. It is instantiated 4*NUM_PADS times from a generate loop.

Test Plan:
- FILTER_LEN = 2, ce_sample every cycle. Pad0 LX = -60 (0xC4) for 2 samples -> run_dir[1] = 1 on the cycle after the second sample. Drop to -40 -> stays 1 (hysteresis). Drop to -20 for 2 samples -> clears.
- Pad0 LY alternates -60 and 0 on every sample -> filter never completes, run_dir[3] stays 0 throughout.
- MODE 2. Pad0 digital up (joy_dig = 0x8) plus LY = +100 held 2 samples -> up and down both merged, SOCD clears both, run_dir[3:0] = 0000.
- Pad1 RX = -128 (0x80), RY = +127 -> aim_dir[7:4] = 0110 (down, left). No overflow at -128.
- Pad1 then pad0 active in sequence -> active_pad goes to 1, then to 0. Both active in the same cycle -> active_pad = 0.
- Assert reset while pad0 LX is one sample short of FILTER_LEN -> all outputs 0. After release, FILTER_LEN fresh samples are required before run_dir[0] asserts.
